// File: rtl/ddr_init_seq_if.sv
// DFI command and levelling-handshake signals between the init sequencer and the PHY side.
interface ddr_init_seq_if #(
  parameter int NUM_RANKS = 2,
  parameter int ADDR_W    = 16,
  parameter int BANK_W    = 3
);
  logic [ADDR_W-1:0]    dfi_address;
  logic [BANK_W-1:0]    dfi_bank;
  logic                 dfi_ras_n;
  logic                 dfi_cas_n;
  logic                 dfi_we_n;
  logic [NUM_RANKS-1:0] dfi_cs_n;
  logic [NUM_RANKS-1:0] dfi_cke;
  logic [NUM_RANKS-1:0] dfi_odt;
  logic                 dfi_reset_n;
  logic                 dfi_wrlvl_en;
  logic                 dfi_wrlvl_resp;
  logic                 dfi_rdlvl_en;
  logic                 dfi_rdlvl_resp;

  modport master (
    output dfi_address, dfi_bank, dfi_ras_n, dfi_cas_n, dfi_we_n,
    output dfi_cs_n, dfi_cke, dfi_odt, dfi_reset_n,
    output dfi_wrlvl_en, dfi_rdlvl_en,
    input  dfi_wrlvl_resp, dfi_rdlvl_resp
  );

  modport slave (
    input  dfi_address, dfi_bank, dfi_ras_n, dfi_cas_n, dfi_we_n,
    input  dfi_cs_n, dfi_cke, dfi_odt, dfi_reset_n,
    input  dfi_wrlvl_en, dfi_rdlvl_en,
    output dfi_wrlvl_resp, dfi_rdlvl_resp
  );
endinterface

// File: rtl/ddr_init_seq.sv
// DDR3 power-up sequencer: reset/CKE timing, per-rank MRS and ZQCL, then optional
// write/read levelling handshakes. Outputs are registered from the next-state decode.
module ddr_init_seq #(
  parameter int NUM_RANKS   = 2,
  parameter int ADDR_W      = 16,
  parameter int BANK_W      = 3,
  parameter int CNT_W       = 16,
  parameter int LVL_TIMEOUT = 4096
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                init_start,
  input  logic [1:0]          lvl_en,
  input  logic [CNT_W-1:0]    t_init0,
  input  logic [CNT_W-1:0]    t_init1,
  input  logic [CNT_W-1:0]    t_xpr,
  input  logic [CNT_W-1:0]    t_mrd,
  input  logic [CNT_W-1:0]    t_mod,
  input  logic [CNT_W-1:0]    t_zqinit,
  input  logic [4*ADDR_W-1:0] mr_val,
  ddr_init_seq_if.master      dfi,
  output logic                init_done,
  output logic [1:0]          init_error
);
  localparam int TO_W = $clog2(LVL_TIMEOUT + 1);
  localparam int RK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RST_LOW, S_CKE_LOW, S_XPR, S_MRS, S_MRS_WAIT,
    S_ZQCL, S_ZQ_WAIT, S_WL, S_RL, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [RK_W-1:0]     rank, rank_nxt;
  logic [1:0]          mr_idx, mr_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [TO_W-1:0]     tcnt;
  logic                clr;
  logic [1:0]          err_nxt;

  logic                rst_n_d, wl_d, rl_d, done_d;
  logic [NUM_RANKS-1:0] cke_d, cs_d;
  logic [2:0]          cmd_d;
  logic [BANK_W-1:0]   bank_d;
  logic [ADDR_W-1:0]   addr_d;

  // Duration minus one, with a zero duration behaving as one cycle.
  function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  logic             last_rank, to_hit;
  logic [CNT_W-1:0] mrs_gap_m1;
  assign last_rank  = (rank == RK_W'(NUM_RANKS - 1));
  assign to_hit     = (tcnt == TO_W'(LVL_TIMEOUT - 1));
  assign mrs_gap_m1 = (mr_idx == 2'd0) ? eff_m1(t_mod) : eff_m1(t_mrd);

  // State register; cnt runs from each command cycle through its wait state.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state            <= S_IDLE;
      rank             <= '0;
      mr_idx           <= '0;
      cnt              <= '0;
      tcnt             <= '0;
      dfi.dfi_reset_n  <= 1'b0;
      dfi.dfi_cke      <= '0;
      dfi.dfi_cs_n     <= '1;
      dfi.dfi_ras_n    <= 1'b1;
      dfi.dfi_cas_n    <= 1'b1;
      dfi.dfi_we_n     <= 1'b1;
      dfi.dfi_bank     <= '0;
      dfi.dfi_address  <= '0;
      dfi.dfi_odt      <= '0;
      dfi.dfi_wrlvl_en <= 1'b0;
      dfi.dfi_rdlvl_en <= 1'b0;
      init_done        <= 1'b0;
      init_error       <= '0;
    end else begin
      state  <= state_nxt;
      rank   <= rank_nxt;
      mr_idx <= mr_nxt;
      cnt    <= clr ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
      tcnt   <= clr ? '0 : ((tcnt == '1) ? tcnt : tcnt + 1'b1);
      dfi.dfi_reset_n  <= rst_n_d;
      dfi.dfi_cke      <= cke_d;
      dfi.dfi_cs_n     <= cs_d;
      {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} <= cmd_d;
      dfi.dfi_bank     <= bank_d;
      dfi.dfi_address  <= addr_d;
      dfi.dfi_odt      <= '0;
      dfi.dfi_wrlvl_en <= wl_d;
      dfi.dfi_rdlvl_en <= rl_d;
      init_done        <= done_d;
      init_error       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rank_nxt  = rank;
    mr_nxt    = mr_idx;
    clr       = 1'b0;
    err_nxt   = init_error;
    case (state)
      S_IDLE: if (init_start) begin
        state_nxt = S_RST_LOW;
        clr       = 1'b1;
      end
      S_RST_LOW: if (cnt == eff_m1(t_init0)) begin
        state_nxt = S_CKE_LOW;
        clr       = 1'b1;
      end
      S_CKE_LOW: if (cnt == eff_m1(t_init1)) begin
        state_nxt = S_XPR;
        clr       = 1'b1;
      end
      S_XPR: if (cnt == eff_m1(t_xpr)) begin
        state_nxt = S_MRS;
        rank_nxt  = '0;
        mr_nxt    = 2'd2;
        clr       = 1'b1;
      end
      S_MRS, S_MRS_WAIT: begin
        state_nxt = S_MRS_WAIT;
        if (cnt == mrs_gap_m1) begin
          state_nxt = S_MRS;
          clr       = 1'b1;
          case (mr_idx)
            2'd2: mr_nxt = 2'd3;
            2'd3: mr_nxt = 2'd1;
            2'd1: mr_nxt = 2'd0;
            default: begin
              mr_nxt = 2'd2;
              if (last_rank) begin
                state_nxt = S_ZQCL;
                rank_nxt  = '0;
              end else begin
                rank_nxt = rank + 1'b1;
              end
            end
          endcase
        end
      end
      S_ZQCL, S_ZQ_WAIT: begin
        state_nxt = S_ZQ_WAIT;
        if (cnt == eff_m1(t_zqinit)) begin
          clr = 1'b1;
          if (last_rank) begin
            rank_nxt  = '0;
            state_nxt = lvl_en[0] ? S_WL : (lvl_en[1] ? S_RL : S_DONE);
          end else begin
            rank_nxt  = rank + 1'b1;
            state_nxt = S_ZQCL;
          end
        end
      end
      // A response on the expiry cycle wins over the timeout.
      S_WL: if (dfi.dfi_wrlvl_resp || to_hit) begin
        state_nxt = lvl_en[1] ? S_RL : S_DONE;
        clr       = 1'b1;
        if (!dfi.dfi_wrlvl_resp) err_nxt[0] = 1'b1;
      end
      S_RL: if (dfi.dfi_rdlvl_resp || to_hit) begin
        state_nxt = S_DONE;
        clr       = 1'b1;
        if (!dfi.dfi_rdlvl_resp) err_nxt[1] = 1'b1;
      end
      S_DONE: if (init_start) begin
        state_nxt = S_RST_LOW;
        clr       = 1'b1;
        err_nxt   = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rst_n_d = 1'b0;
    cke_d   = '0;
    cs_d    = '1;
    cmd_d   = 3'b111;
    bank_d  = '0;
    addr_d  = '0;
    wl_d    = 1'b0;
    rl_d    = 1'b0;
    done_d  = 1'b0;
    case (state_nxt)
      S_IDLE, S_RST_LOW: ;
      S_CKE_LOW: rst_n_d = 1'b1;
      default: begin
        rst_n_d = 1'b1;
        cke_d   = '1;
      end
    endcase
    case (state_nxt)
      S_MRS: begin
        cs_d[rank_nxt] = 1'b0;
        cmd_d          = 3'b000;
        bank_d         = BANK_W'(mr_nxt);
        addr_d         = mr_val[int'(mr_nxt)*ADDR_W +: ADDR_W];
      end
      S_ZQCL: begin
        cs_d[rank_nxt] = 1'b0;
        cmd_d          = 3'b110;
        addr_d[10]     = 1'b1;
      end
      S_WL:   wl_d   = 1'b1;
      S_RL:   rl_d   = 1'b1;
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: command trace timing, zero delays, levelling, restart, mid-run reset.
module tb_ddr_init_seq;
  localparam int NR = 2, AW = 16, BW = 3, CW = 16, LT = 64;

  logic            core_clk = 1'b0;
  logic            core_rst = 1'b1;
  logic            init_start = 1'b0;
  logic [1:0]      lvl_en = 2'b00;
  logic [CW-1:0]   t_init0, t_init1, t_xpr, t_mrd, t_mod, t_zqinit;
  logic [4*AW-1:0] mr_val;
  logic            init_done;
  logic [1:0]      init_error;

  ddr_init_seq_if #(.NUM_RANKS(NR), .ADDR_W(AW), .BANK_W(BW)) dfi();

  ddr_init_seq #(.NUM_RANKS(NR), .ADDR_W(AW), .BANK_W(BW), .CNT_W(CW), .LVL_TIMEOUT(LT)) dut (
    .core_clk(core_clk), .core_rst(core_rst), .init_start(init_start), .lvl_en(lvl_en),
    .t_init0(t_init0), .t_init1(t_init1), .t_xpr(t_xpr), .t_mrd(t_mrd), .t_mod(t_mod),
    .t_zqinit(t_zqinit), .mr_val(mr_val), .dfi(dfi), .init_done(init_done), .init_error(init_error)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic rst_n; logic [NR-1:0] cke, cs_n, odt; logic [2:0] cmd;
    logic [BW-1:0] bank; logic [AW-1:0] addr; logic wl, rl, done; logic [1:0] err;
  } snap_t;

  snap_t snap [256];
  int ncap, done_cyc;
  int errors = 0, checks = 0;

  logic [AW-1:0] mrs [4] = '{16'h0520, 16'h0044, 16'h0018, 16'h0004};
  int            exp_cyc [10] = '{15, 19, 23, 27, 39, 43, 47, 51, 63, 83};
  logic [1:0]    exp_cs  [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
  int            exp_mr  [10] = '{2, 3, 1, 0, 2, 3, 1, 0, -1, -1};

  task automatic set_t(input int a, input int b, input int c, input int d, input int e, input int f);
    t_init0 = CW'(a); t_init1 = CW'(b); t_xpr = CW'(c);
    t_mrd = CW'(d); t_mod = CW'(e); t_zqinit = CW'(f);
  endtask

  // Pulses init_start, then records one snapshot per cycle (cycle 0 = first cycle after the pulse).
  task automatic capture(input int ncyc, input int wr_at, input int rd_at, input int xs_at);
    ncap = 0; done_cyc = -1;
    init_start = 1'b1;
    for (int n = 0; n < ncyc && n < 256; n++) begin
      @(negedge core_clk);
      init_start = (n == xs_at);
      snap[n].rst_n = dfi.dfi_reset_n; snap[n].cke = dfi.dfi_cke;
      snap[n].cs_n = dfi.dfi_cs_n; snap[n].odt = dfi.dfi_odt;
      snap[n].cmd = {dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n};
      snap[n].bank = dfi.dfi_bank; snap[n].addr = dfi.dfi_address;
      snap[n].wl = dfi.dfi_wrlvl_en; snap[n].rl = dfi.dfi_rdlvl_en;
      snap[n].done = init_done; snap[n].err = init_error;
      ncap = n + 1;
      dfi.dfi_wrlvl_resp = (n == wr_at);
      dfi.dfi_rdlvl_resp = (n == rd_at);
      if (init_done === 1'b1) begin done_cyc = n; break; end
    end
    dfi.dfi_wrlvl_resp = 1'b0; dfi.dfi_rdlvl_resp = 1'b0; init_start = 1'b0;
  endtask

  // sel: 0 reset_n, 1 cke all high, 2 wrlvl_en, 3 rdlvl_en, 4 command issued, 5 odt nonzero
  function automatic bit hit(input int n, input int sel);
    case (sel)
      0: return snap[n].rst_n === 1'b1;
      1: return snap[n].cke === 2'b11;
      2: return snap[n].wl === 1'b1;
      3: return snap[n].rl === 1'b1;
      4: return snap[n].cs_n !== 2'b11;
      default: return snap[n].odt !== 2'b00;
    endcase
  endfunction

  function automatic int first_cyc(input int sel);
    for (int n = 0; n < ncap; n++) if (hit(n, sel)) return n;
    return -1;
  endfunction

  function automatic int count_hi(input int sel);
    int c = 0;
    for (int n = 0; n < ncap; n++) if (hit(n, sel)) c++;
    return c;
  endfunction

  task automatic test_reset();
    core_rst = 1'b1; init_start = 1'b1;
    repeat (3) @(negedge core_clk);
    checks++; if (dfi.dfi_reset_n !== 1'b0 || dfi.dfi_cke !== 2'b00) begin
      errors++; $display("FAIL reset_rst_cke: got %b/%b want 0/00", dfi.dfi_reset_n, dfi.dfi_cke); end
    checks++; if ({dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_nop: got %b%b%b%b want 11111", dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n); end
    checks++; if ({dfi.dfi_address, dfi.dfi_bank, dfi.dfi_odt} !== '0) begin
      errors++; $display("FAIL reset_addr: got %h/%h/%b want 0", dfi.dfi_address, dfi.dfi_bank, dfi.dfi_odt); end
    checks++; if ({dfi.dfi_wrlvl_en, dfi.dfi_rdlvl_en, init_done, init_error} !== 5'b0) begin
      errors++; $display("FAIL reset_status: got %b%b%b%b want 00000", dfi.dfi_wrlvl_en, dfi.dfi_rdlvl_en, init_done, init_error); end
    core_rst = 1'b0; init_start = 1'b0;
    repeat (4) @(negedge core_clk);
    checks++; if (dfi.dfi_reset_n !== 1'b0 || dfi.dfi_cs_n !== 2'b11) begin
      errors++; $display("FAIL reset_idle_hold: got rst_n=%b cs=%b want 0/11", dfi.dfi_reset_n, dfi.dfi_cs_n); end
  endtask

  task automatic test_full_trace();
    set_t(5, 7, 3, 4, 12, 20); lvl_en = 2'b00;
    capture(200, -1, -1, -1);
    checks++; if (count_hi(4) != 10) begin errors++; $display("FAIL trace_cmd_count: got %0d want 10", count_hi(4)); end
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] ea; logic [2:0] ec; logic [BW-1:0] eb;
      ea = (exp_mr[i] < 0) ? 16'h0400 : mrs[exp_mr[i]];
      ec = (exp_mr[i] < 0) ? 3'b110 : 3'b000;
      eb = (exp_mr[i] < 0) ? '0 : BW'(exp_mr[i]);
      checks++;
      if ({snap[exp_cyc[i]].cs_n, snap[exp_cyc[i]].cmd, snap[exp_cyc[i]].bank, snap[exp_cyc[i]].addr} !== {exp_cs[i], ec, eb, ea}) begin
        errors++; $display("FAIL trace_cmd%0d @%0d: got cs=%b cmd=%b bank=%0d addr=%h want cs=%b cmd=%b bank=%0d addr=%h",
          i, exp_cyc[i], snap[exp_cyc[i]].cs_n, snap[exp_cyc[i]].cmd, snap[exp_cyc[i]].bank, snap[exp_cyc[i]].addr, exp_cs[i], ec, eb, ea);
      end
    end
    checks++; if (first_cyc(0) != 5) begin errors++; $display("FAIL trace_rstn_rise: got %0d want 5", first_cyc(0)); end
    checks++; if (first_cyc(1) != 12) begin errors++; $display("FAIL trace_cke_rise: got %0d want 12", first_cyc(1)); end
    checks++; if (done_cyc != 103) begin errors++; $display("FAIL trace_done_cyc: got %0d want 103", done_cyc); end
    checks++; if (count_hi(5) != 0) begin errors++; $display("FAIL trace_odt: got %0d nonzero cycles want 0", count_hi(5)); end
  endtask

  task automatic test_zero_delays();
    set_t(0, 0, 0, 0, 0, 0); lvl_en = 2'b00;
    capture(200, -1, -1, -1);
    checks++; if (count_hi(4) != 10) begin errors++; $display("FAIL zero_cmd_count: got %0d want 10", count_hi(4)); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (snap[3 + i].cs_n !== exp_cs[i]) begin
        errors++; $display("FAIL zero_cmd%0d @%0d: got cs=%b want %b", i, 3 + i, snap[3 + i].cs_n, exp_cs[i]); end
    end
    checks++; if (first_cyc(0) != 1 || first_cyc(1) != 2) begin
      errors++; $display("FAIL zero_phases: got rstn@%0d cke@%0d want 1/2", first_cyc(0), first_cyc(1)); end
    checks++; if (done_cyc != 13) begin errors++; $display("FAIL zero_done_cyc: got %0d want 13", done_cyc); end
  endtask

  task automatic test_levelling();
    set_t(0, 0, 0, 0, 0, 0); lvl_en = 2'b11;
    capture(200, 22, -1, -1);
    checks++; if (first_cyc(2) != 13 || count_hi(2) != 10) begin
      errors++; $display("FAIL lvl_wrlvl: got first=%0d len=%0d want 13/10", first_cyc(2), count_hi(2)); end
    checks++; if (first_cyc(3) != 23 || count_hi(3) != LT) begin
      errors++; $display("FAIL lvl_rdlvl: got first=%0d len=%0d want 23/%0d", first_cyc(3), count_hi(3), LT); end
    checks++; if (done_cyc != 87) begin errors++; $display("FAIL lvl_done_cyc: got %0d want 87", done_cyc); end
    checks++; if (done_cyc < 0 || snap[(done_cyc < 0) ? 0 : done_cyc].err !== 2'b10) begin
      errors++; $display("FAIL lvl_error: got %b want 10", init_error); end
  endtask

  task automatic test_restart();
    set_t(5, 7, 3, 4, 12, 20); lvl_en = 2'b00;
    capture(200, -1, -1, -1);
    checks++; if (snap[0].done !== 1'b0 || snap[0].err !== 2'b00) begin
      errors++; $display("FAIL restart_clear: got done=%b err=%b want 0/00", snap[0].done, snap[0].err); end
    checks++; if (snap[0].rst_n !== 1'b0 || first_cyc(0) != 5) begin
      errors++; $display("FAIL restart_rst_low: got rstn0=%b rise=%0d want 0/5", snap[0].rst_n, first_cyc(0)); end
    checks++; if (done_cyc != 103) begin errors++; $display("FAIL restart_done_cyc: got %0d want 103", done_cyc); end
  endtask

  task automatic test_rdlvl_exact_timeout();
    set_t(0, 0, 0, 0, 0, 0); lvl_en = 2'b10;
    capture(200, -1, 76, -1);
    checks++; if (count_hi(2) != 0) begin errors++; $display("FAIL exact_wl_skip: got %0d want 0", count_hi(2)); end
    checks++; if (first_cyc(3) != 13 || count_hi(3) != LT) begin
      errors++; $display("FAIL exact_rdlvl: got first=%0d len=%0d want 13/%0d", first_cyc(3), count_hi(3), LT); end
    checks++; if (done_cyc != 77 || init_error !== 2'b00) begin
      errors++; $display("FAIL exact_done: got cyc=%0d err=%b want 77/00", done_cyc, init_error); end
  endtask

  task automatic test_start_in_xpr();
    set_t(5, 7, 3, 4, 12, 20); lvl_en = 2'b00;
    capture(200, -1, -1, 12);
    checks++; if (first_cyc(4) != 15 || count_hi(4) != 10) begin
      errors++; $display("FAIL xpr_start_cmds: got first=%0d n=%0d want 15/10", first_cyc(4), count_hi(4)); end
    checks++; if (done_cyc != 103) begin errors++; $display("FAIL xpr_start_done: got %0d want 103", done_cyc); end
  endtask

  task automatic test_mid_reset();
    set_t(5, 7, 3, 4, 12, 20); lvl_en = 2'b00;
    capture(48, -1, -1, -1);
    checks++; if ({snap[47].cs_n, snap[47].cmd, snap[47].bank} !== {2'b01, 3'b000, 3'd1}) begin
      errors++; $display("FAIL midrst_mr1: got cs=%b cmd=%b bank=%0d want 01/000/1", snap[47].cs_n, snap[47].cmd, snap[47].bank); end
    core_rst = 1'b1;
    @(negedge core_clk);
    checks++; if ({dfi.dfi_reset_n, dfi.dfi_cke, dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} !== 8'b0_00_11_111) begin
      errors++; $display("FAIL midrst_ctrl: got %b%b%b%b%b%b want 00011111", dfi.dfi_reset_n, dfi.dfi_cke, dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n); end
    checks++; if ({dfi.dfi_address, dfi.dfi_bank, init_done} !== '0) begin
      errors++; $display("FAIL midrst_addr: got %h/%h/%b want 0", dfi.dfi_address, dfi.dfi_bank, init_done); end
    core_rst = 1'b0;
    repeat (5) @(negedge core_clk);
    checks++; if (dfi.dfi_reset_n !== 1'b0 || dfi.dfi_cke !== 2'b00) begin
      errors++; $display("FAIL midrst_idle: got rstn=%b cke=%b want 0/00", dfi.dfi_reset_n, dfi.dfi_cke); end
    capture(200, -1, -1, -1);
    checks++; if (count_hi(4) != 10 || snap[47].cs_n !== 2'b01 || snap[63].cmd !== 3'b110) begin
      errors++; $display("FAIL midrst_replay: got n=%0d cs47=%b cmd63=%b want 10/01/110", count_hi(4), snap[47].cs_n, snap[63].cmd); end
    checks++; if (done_cyc != 103) begin errors++; $display("FAIL midrst_done: got %0d want 103", done_cyc); end
  endtask

  initial begin
    mr_val = {mrs[3], mrs[2], mrs[1], mrs[0]};
    dfi.dfi_wrlvl_resp = 1'b0; dfi.dfi_rdlvl_resp = 1'b0;
    set_t(5, 7, 3, 4, 12, 20);
    @(negedge core_clk);
    test_reset();
    test_full_trace();
    test_zero_delays();
    test_levelling();
    test_restart();
    test_rdlvl_exact_timeout();
    test_start_in_xpr();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
